// File: rtl/spi_pkg.sv
// Constants and state encoding shared by spi_master and spi_slave_regs.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 16;

  localparam logic [3:0] CMD_WR = 4'b1000;
  localparam logic [3:0] CMD_RD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    WAIT_CS
  } spi_slv_st_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus single-cycle edge pulses
// derived from one extra flop behind the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Not reset: the level must track the pin during reset so the FSM can see
  // whether a frame is already in flight when reset releases.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave terminating 24-bit {cmd, addr, data} frames into a 16x16
// register file, with a local read port and write-commit notification.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy,
  input  logic [ADDR_W-1:0] loc_rd_addr,
  output logic [DATA_W-1:0] loc_rd_data
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i  (sys_clk),
    .d_i    (spi_sck),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i  (sys_clk),
    .d_i    (spi_cs),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  always_ff @(posedge sys_clk) begin
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_slv_st_t             state_q;
  logic [4:0]              bit_cnt_q;
  logic [FRAME_BITS-1:0]   rx_sr_q;
  logic [DATA_W-1:0]       tx_sr_q;
  logic                    rd_act_q;
  logic                    miso_q;
  logic                    wr_valid_q;
  logic                    frame_err_q;
  logic                    busy_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wr_data_q;
  logic [DATA_W-1:0]       loc_rd_data_q;
  logic [DATA_W-1:0]       regs_q [2**ADDR_W];

  logic [3:0]        f_cmd;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              len_ok;

  assign f_cmd  = rx_sr_q[FRAME_BITS-1 -: 4];
  assign f_addr = rx_sr_q[DATA_W +: ADDR_W];
  assign f_data = rx_sr_q[DATA_W-1:0];
  assign len_ok = (bit_cnt_q == 5'(FRAME_BITS));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= cs_s ? IDLE : WAIT_CS;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      rd_act_q      <= 1'b0;
      miso_q        <= 1'b0;
      wr_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      loc_rd_data_q <= '0;
      for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      loc_rd_data_q <= regs_q[loc_rd_addr];

      unique case (state_q)
        IDLE: begin
          miso_q   <= 1'b0;
          rd_act_q <= 1'b0;
          // Mode-0 master idles SCK low; a CS fall with SCK high is not a frame start.
          if (cs_fall && !sck_s) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            miso_q   <= 1'b0;
            rd_act_q <= 1'b0;
            state_q  <= COMMIT;
          end else begin
            if (sck_rise) begin
              rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], mosi_s};
              if (bit_cnt_q != 5'd31) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
            if (sck_fall) begin
              // Header complete: start a read on this fall, shift on the next 15.
              if (bit_cnt_q == 5'd8 && rx_sr_q[7:4] == CMD_RD) begin
                tx_sr_q  <= regs_q[rx_sr_q[3:0]];
                miso_q   <= regs_q[rx_sr_q[3:0]][DATA_W-1];
                rd_act_q <= 1'b1;
              end else if (rd_act_q && bit_cnt_q < 5'(FRAME_BITS)) begin
                tx_sr_q <= tx_sr_q << 1;
                miso_q  <= tx_sr_q[DATA_W-2];
              end else begin
                miso_q   <= 1'b0;
                rd_act_q <= 1'b0;
              end
            end
          end
        end

        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (len_ok && f_cmd == CMD_WR) begin
            regs_q[f_addr] <= f_data;
            wr_addr_q      <= f_addr;
            wr_data_q      <= f_data;
            wr_valid_q     <= 1'b1;
          end else if (!(len_ok && f_cmd == CMD_RD)) begin
            frame_err_q <= 1'b1;
          end
        end

        WAIT_CS: begin
          miso_q   <= 1'b0;
          rd_act_q <= 1'b0;
          if (cs_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign loc_rd_data = loc_rd_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: frames are driven at SCK = sys_clk/10 and
// commit events are checked by a monitor against a queue of expected events.
module tb_spi_slave_regs;

  localparam int unsigned SYNC = 2;
  localparam int unsigned NO_RST = 999;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        busy;
  logic [3:0]  loc_rd_addr = 4'h0;
  logic [15:0] loc_rd_data;

  always #10 sys_clk = ~sys_clk;

  spi_slave_regs #(.SYNC_STAGES(SYNC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .spi_sck     (spi_sck),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_err   (frame_err),
    .busy        (busy),
    .loc_rd_addr (loc_rd_addr),
    .loc_rd_data (loc_rd_data)
  );

  typedef struct {
    logic        is_wr;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc = 0;
  int unsigned cs_rise_cyc = 0;

  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic expect_evt(input logic is_wr, input logic [3:0] addr, input logic [15:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Monitor: every commit pulse must match the oldest expected event.
  always @(negedge sys_clk) begin
    if (!sys_rst && (wr_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, wr_valid, frame_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind", {30'd0, wr_valid, frame_err}, mon_e.is_wr ? 32'd2 : 32'd1);
        check("event_latency", cyc - cs_rise_cyc, SYNC + 2);
        if (mon_e.is_wr) begin
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
        end
      end
    end
  end

  // word is left-aligned; bits beyond the 24-bit frame shift out as zeros.
  task automatic spi_frame(input logic [31:0] word, input int unsigned nbits,
                           input int unsigned rst_at, output logic [31:0] miso_bits);
    logic [31:0] w;
    w = word;
    miso_bits = '0;
    spi_cs = 1'b0;
    #100;
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("busy_wait_cs", 32'(busy), 32'd1);
      end
      spi_mosi = w[31];
      w = w << 1;
      #100 spi_sck = 1'b1;
      miso_bits = {miso_bits[30:0], spi_miso};
      #100 spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
    #100 spi_cs = 1'b1;
    cs_rise_cyc = cyc;
    #300;
    check("events_drained", sb.size(), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    @(negedge sys_clk);
    loc_rd_addr = a;
    @(negedge sys_clk);
    check(name, 32'(loc_rd_data), 32'(exp));
    #5;
  endtask

  initial begin
    logic [31:0] mb;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_loc_rd", 32'(loc_rd_data), 32'd0);
    #5;

    expect_evt(1'b1, 4'h4, 16'hE6B7);
    spi_frame({24'h84E6B7, 8'h00}, 24, NO_RST, mb);
    rd_chk("loc_rd_after_write", 4'h4, 16'hE6B7);

    spi_frame({24'h040000, 8'h00}, 24, NO_RST, mb);
    check("miso_header_zero", 32'(mb[23:16]), 32'd0);
    check("miso_read_data", 32'(mb[15:0]), 32'h0000E6B7);
    rd_chk("loc_rd_after_read", 4'h4, 16'hE6B7);

    expect_evt(1'b0, 4'h0, 16'h0000);
    spi_frame({24'h84E6B7, 8'h00}, 20, NO_RST, mb);
    rd_chk("loc_rd_after_short", 4'h4, 16'hE6B7);

    expect_evt(1'b0, 4'h0, 16'h0000);
    spi_frame({24'h841111, 8'h00}, 26, NO_RST, mb);
    rd_chk("loc_rd_after_long", 4'h4, 16'hE6B7);

    expect_evt(1'b0, 4'h0, 16'h0000);
    spi_frame({24'hF31234, 8'h00}, 24, NO_RST, mb);
    rd_chk("loc_rd_after_unknown", 4'h3, 16'h0000);

    spi_frame({24'h84ABCD, 8'h00}, 24, 10, mb);
    check("busy_after_wait_cs", 32'(busy), 32'd0);
    rd_chk("loc_rd_cleared_by_rst", 4'h4, 16'h0000);

    expect_evt(1'b1, 4'h1, 16'h00FF);
    spi_frame({24'h8100FF, 8'h00}, 24, NO_RST, mb);
    rd_chk("loc_rd_after_rewrite", 4'h1, 16'h00FF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 slave that terminates the 24-bit command frames issued by the team's `spi_master`. Each frame is {cmd[3:0], addr[3:0], data[15:0]}, MSB first. The block holds a 16 × 16-bit register file:
- Write frames update one register and are announced to local logic.
- Read frames return a register on MISO.
- All SPI pins are asynchronous to `sys_clk` and are oversampled.

## Interface
- `CMD_WR`, 4'b1000: write command code.
- `CMD_RD`, 4'b0000: read command code.
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sck`, `spi_cs`, `spi_mosi` (min 2).
- `sys_clk`  in  1  system clock, 50 MHz; SCK ≤ sys_clk/10.
- `sys_rst`  in  1  synchronous, active-high reset.
- `spi_sck`  in  1  SPI clock from master, idle low.
- `spi_cs`  in  1  chip select, active low.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data. Driven, never tri-stated.
- `wr_valid`  out  1  one-cycle pulse: a write frame committed.
- `wr_addr`  out  4  address of the last committed write.
- `wr_data`  out  16  data of the last committed write.
- `frame_err`  out  1  one-cycle pulse: frame rejected.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `loc_rd_addr`  in  4  local read address.
- `loc_rd_data`  out  16  registered read data, valid 1 cycle after `loc_rd_addr`.

## Operation
- Input conditioning:
  - `spi_sck`, `spi_cs` and `spi_mosi` each pass through SYNC_STAGES flops.
  - Edge detection on synced SCK and CS uses one extra flop.
  - All logic uses the synced signals only.
- State machine: IDLE → SHIFT → COMMIT → IDLE, plus a WAIT_CS state.
- IDLE: on a synced CS falling edge, clear `bit_cnt` and the shift register, then go to SHIFT.
- SHIFT, SCK rising edge:
  - `rx_sr <= {rx_sr[22:0], mosi_s}`.
  - `bit_cnt` increments, saturating at 31.
- SHIFT, read path:
  - At the first SCK falling edge after `bit_cnt` reaches 8: if `rx_sr[7:4] == CMD_RD`, load `tx_sr` with `regs[rx_sr[3:0]]`.
  - At that same falling edge, drive `spi_miso = tx_sr[15]`.
  - On each later SCK falling edge, shift `tx_sr` left and drive the new MSB.
  - Otherwise `spi_miso` = 0.
- SHIFT, CS rising edge: go to COMMIT.
- COMMIT (one cycle):
  - If `bit_cnt == 24` and cmd == `CMD_WR`: write `regs[addr] <= data`, update `wr_addr`/`wr_data`, pulse `wr_valid`.
  - Else if `bit_cnt == 24` and cmd == `CMD_RD`: no side effect.
  - Otherwise (wrong bit count, or unknown cmd): pulse `frame_err`, no register change.
  - Return to IDLE.
- WAIT_CS:
  - Entered after reset if synced CS is low.
  - Leaves to IDLE only once CS is seen high. A frame already in flight at reset release is never accepted.
- `spi_miso` is 0 whenever CS is high or outside the 16 data bits of a read.

## Timing
- Reset values:
  - All outputs 0.
  - `regs` all 0x0000.
  - State IDLE, or WAIT_CS if synced CS is low when reset deasserts.
- Edge detection latency: SYNC_STAGES+1 sys_clk cycles from the pin edge (3 at default).
- MISO setup margin:
  - MISO updates 3 cycles after the pin SCK falling edge.
  - At SCK = 5 MHz the master's next rising edge arrives 5 cycles after the falling edge, leaving ≥2 cycles of setup.
- `wr_valid` / `frame_err`: asserted exactly SYNC_STAGES+2 cycles after the pin CS rising edge, high for 1 cycle.
- Register write and `wr_valid` occur in the same cycle. `loc_rd_data` reflects the new value from the following cycle.
- If a local read and an SPI commit hit the same address in the same cycle, `loc_rd_data` returns the old value.
- Synchronous reset mid-frame: abort the frame with no `wr_valid` and no `frame_err`. Registers are cleared.
- CS toggling within one sys_clk (glitch shorter than the synchronizer) is not guaranteed to be seen. This is allowed.

## Structure
- Shared package `spi_pkg` holds:
  - `FRAME_BITS = 24`, `ADDR_W = 4`, `DATA_W = 16`.
  - `CMD_WR` and `CMD_RD` values, so `spi_master` and this block share them.
  - State enum `spi_slv_st_t` {IDLE, SHIFT, COMMIT, WAIT_CS}.
- One sub-module `spi_sync_edge`:
  - Parameterized synchronizer plus rise/fall pulse outputs.
  - Instantiated for SCK and CS; MOSI uses its synced output only.

## Test plan
- Write: frame 0x84E6B7 at SCK 5 MHz → exactly one `wr_valid`, `wr_addr` = 4, `wr_data` = 0xE6B7. `loc_rd_addr` = 4 returns 0xE6B7.
- Read-back: after the write above, frame 0x04_0000 → MISO bits 9–24 sampled on SCK rising edges = 0xE6B7, no `wr_valid`, no `frame_err`, `regs` unchanged.
- Short frame: CS rises after 20 SCK pulses carrying 0x84E6B… → one `frame_err` pulse, `regs[4]` unchanged.
- Long frame: 26 SCK pulses → one `frame_err` pulse, no write.
- Unknown command: frame 0xF31234 → one `frame_err` pulse, `regs[3]` stays 0.
- Reset mid-frame: assert `sys_rst` after 10 bits with CS held low, then finish the 24 bits → no `wr_valid`, state WAIT_CS until CS rises. The next clean write to addr 1 with 0x00FF succeeds.
